cp0_ctrl: RTL and testbench
===========================

# cp0_ctrl

Coprocessor-0 controller for the pipelined MIPS core, sitting at the memory stage. It consumes the per-instruction exception code that the execute stage and ALU produce, arbitrates exceptions against external hardware interrupts, and drives `Req`, the flush/redirect request the execute-stage multiply/divide logic uses to cancel work. It holds SR, Cause, EPC and PRId, and serves `mtc0`, `mfc0` and `eret`.

## Interface
- `PRID_VALUE`, default 32'h0000_2024, value read from PRId (reg 15).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `en`  in  1  `mtc0` write strobe from the M-stage instruction.
- `cp0_addr`  in  5  CP0 register number for `mtc0`/`mfc0`.
- `cp0_wdata`  in  32  `mtc0` data.
- `vpc`  in  32  PC of the M-stage instruction, or of the next valid instruction if M holds a bubble.
- `bd_in`  in  1  M-stage instruction is in a branch delay slot.
- `exc_code_in`  in  5  exception code of the M-stage instruction; `ExcNone` means no exception.
- `eret`  in  1  M-stage instruction is `eret`.
- `hw_int`  in  6  external interrupt lines (timers, interrupt generator).
- `cp0_rdata`  out  32  `mfc0` read data, combinational.
- `epc_out`  out  32  EPC for the `eret` redirect.
- `Req`  out  1  take exception or interrupt this cycle.

## Operation
- **SR (12):** IM = [15:10], EXL = [1], IE = [0]. All other bits read as 0.
- **Cause (13):** BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read as 0.
- **EPC (14):** 32-bit register.
- **PRId (15):** read-only register.
- **Cause.IP:** loaded with the (optionally synchronised) `hw_int` on every edge.
- **`int_req`** = `|(IP_src & IM) & IE & ~EXL`. `IP_src` is the same-cycle `hw_int` value, after the synchroniser when one is present.
- **`exc_req`** = `(exc_code_in != ExcNone) & ~EXL`.
- **`Req`** = `int_req | exc_req`, combinational.
- **Priority:** an interrupt outranks a synchronous exception in the same cycle.
- **On an edge with `Req`:**
  - EXL is set to 1.
  - BD takes `bd_in`.
  - ExcCode takes 5'd0 on an interrupt, otherwise `exc_code_in`.
  - EPC takes `bd_in ? vpc-4 : vpc`, computed mod 2^32.
- **`eret` (and `Req` low):** EXL clears on the next edge.
- **`epc_out`:** EPC is forwarded directly, except that a same-cycle `mtc0` to EPC is bypassed to `epc_out`.
- **`mtc0` (`en`, `Req` low):**
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes all 32 bits of EPC.
  - Writes to 13, 15 or any other address are dropped.
- **`Req` and `en` together:** `Req` wins and the write is discarded.
- **`mfc0`:** addresses 12/13/14/15 return the register value; any other address returns 0. Reads show the pre-edge value; there is no write-through on reads.

## Timing
- **Reset values:** SR = 0, Cause = 0, EPC = 0, synchroniser flops = 0. Therefore `Req` = 0, `epc_out` = 0, and `cp0_rdata` = 0 for every address except 15.
- **`Req` latency:** 0 cycles from its inputs (purely combinational).
- **State update latency:** register updates land at the edge that closes the cycle in which `Req`, `eret` or `en` is sampled.
- **EXL masking:** a second exception in the cycle after `Req` is masked, because EXL is already 1.
- **Reset during an active EXL or a pending interrupt:** state clears asynchronously, and `Req` drops the same instant.

## Configuration
- **`CP0_INT_SYNC_EN` defined:**
  - `hw_int` passes through a 2-flop synchroniser before feeding IP and `int_req`.
  - Interrupt-to-`Req` latency is 2 edges.
- **`CP0_INT_SYNC_EN` undefined:**
  - `hw_int` is used directly.
  - `Req` asserts in the same cycle as the interrupt.
  - IP reflects `hw_int` after 1 edge.

## Test plan
- **Arithmetic overflow:** reset, then present `exc_code_in`=5'd12 (Ov), `vpc`=32'h3008, `bd_in`=0 → `Req`=1 that cycle. After the edge: Cause[6:2]=12, EPC=32'h3008, SR[1]=1.
- **Delay-slot exception:** `exc_code_in`=5'd4, `vpc`=32'h3010, `bd_in`=1 → EPC=32'h300C and Cause[31]=1.
- **Interrupt (macro undefined):**
  - `mtc0` SR = 32'h0000_0401 → SR reads 32'h0000_0401.
  - Raise `hw_int`=6'b000001 → `Req`=1 in the same cycle. After the edge: ExcCode=0, Cause[10]=1.
- **Interrupt with `CP0_INT_SYNC_EN`:** same as above, except `Req` rises exactly 2 edges after `hw_int`.
- **Simultaneous interrupt and Syscall:** `hw_int` enabled together with `exc_code_in`=5'd8 → ExcCode=0. In the same cycle, `mtc0` EPC=32'hDEAD is dropped.
- **`eret` and reset mid-handler:**
  - `eret` with EPC=32'h3008 → `epc_out`=32'h3008 and SR[1] clears after the edge.
  - Pulse `reset` while EXL=1 → all registers read 0 immediately.

Source files
------------

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: Coprocessor-0 controller for the M stage of the pipelined MIPS core.
// Arbitrates synchronous exceptions against hardware interrupts, drives Req,
// and holds SR / Cause / EPC / PRId for mtc0, mfc0 and eret.
// Optional build macro: CP0_INT_SYNC_EN adds a 2-flop synchroniser on hw_int.
module cp0_ctrl #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic        Req
);

    localparam logic [4:0] EXC_NONE  = 5'd0;
    localparam logic [4:0] ADDR_SR   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC  = 5'd14;
    localparam logic [4:0] ADDR_PRID = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [5:0]  ip_src;
    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;

`ifdef CP0_INT_SYNC_EN
    logic [5:0] int_sync1;
    logic [5:0] int_sync2;

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_sync1 <= '0;
            int_sync2 <= '0;
        end else begin
            int_sync1 <= hw_int;
            int_sync2 <= int_sync1;
        end
    end

    assign ip_src = int_sync2;
`else
    assign ip_src = hw_int;
`endif

    assign int_req = (|(ip_src & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exc_code_in != EXC_NONE) & ~sr_exl;
    assign Req     = int_req | exc_req;

    // mtc0 only lands when no exception is being taken in the same cycle.
    assign wr_sr  = en & ~Req & (cp0_addr == ADDR_SR);
    assign wr_epc = en & ~Req & (cp0_addr == ADDR_EPC);

    // The eret redirect sees a same-cycle mtc0 to EPC without waiting for the edge.
    assign epc_out = wr_epc ? cp0_wdata : epc;

    // Architectural register update: exception entry beats mtc0 and eret.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= ip_src;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                cause_exc <= int_req ? 5'd0 : exc_code_in;
                epc       <= bd_in ? (vpc - 32'd4) : vpc;
            end else begin
                if (wr_sr) begin
                    sr_im  <= cp0_wdata[15:10];
                    sr_exl <= cp0_wdata[1];
                    sr_ie  <= cp0_wdata[0];
                end
                if (wr_epc) begin
                    epc <= cp0_wdata;
                end
                // eret leaving the handler takes precedence over a same-cycle SR write of EXL.
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux; shows pre-edge register contents.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
            ADDR_CAUSE: cp0_rdata = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'b00};
            ADDR_EPC:   cp0_rdata = epc;
            ADDR_PRID:  cp0_rdata = PRID_VALUE;
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed checks of cp0_ctrl exception entry, interrupts, mtc0/mfc0,
// eret and asynchronous reset. Honors CP0_INT_SYNC_EN for interrupt latency.
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        Req;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd_val;

    cp0_ctrl #(.PRID_VALUE(32'h0000_2024)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .eret        (eret),
        .hw_int      (hw_int),
        .cp0_rdata   (cp0_rdata),
        .epc_out     (epc_out),
        .Req         (Req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        en = 1'b0;
        cp0_addr = '0;
        cp0_wdata = '0;
        vpc = '0;
        bd_in = 1'b0;
        exc_code_in = 5'd0;
        eret = 1'b0;
        hw_int = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_req", {31'b0, Req}, 32'd0);
        check("rst_epc_out", epc_out, 32'd0);
        rd(5'd12, rd_val); check("rst_sr", rd_val, 32'd0);
        rd(5'd13, rd_val); check("rst_cause", rd_val, 32'd0);
        rd(5'd14, rd_val); check("rst_epc", rd_val, 32'd0);
        rd(5'd15, rd_val); check("rst_prid", rd_val, 32'h0000_2024);
        @(negedge clk);
        reset = 1'b0;

        // Arithmetic overflow
        @(negedge clk);
        exc_code_in = 5'd12; vpc = 32'h3008; bd_in = 1'b0;
        #1;
        check("ov_req", {31'b0, Req}, 32'd1);
        tick();
        exc_code_in = 5'd0;
        rd(5'd13, rd_val); check("ov_cause", rd_val, 32'h0000_0030);
        rd(5'd14, rd_val); check("ov_epc", rd_val, 32'h0000_3008);
        rd(5'd12, rd_val); check("ov_sr", rd_val, 32'h0000_0002);

        // Second exception masked by EXL
        @(negedge clk);
        exc_code_in = 5'd4;
        #1;
        check("exl_mask_req", {31'b0, Req}, 32'd0);
        tick();
        exc_code_in = 5'd0;
        rd(5'd13, rd_val); check("exl_mask_cause", rd_val, 32'h0000_0030);

        // eret
        @(negedge clk);
        eret = 1'b1;
        #1;
        check("eret_epc_out", epc_out, 32'h0000_3008);
        tick();
        eret = 1'b0;
        rd(5'd12, rd_val); check("eret_sr", rd_val, 32'h0000_0000);

        // Delay-slot exception
        @(negedge clk);
        exc_code_in = 5'd4; vpc = 32'h3010; bd_in = 1'b1;
        #1;
        check("ds_req", {31'b0, Req}, 32'd1);
        tick();
        exc_code_in = 5'd0; bd_in = 1'b0;
        rd(5'd14, rd_val); check("ds_epc", rd_val, 32'h0000_300C);
        rd(5'd13, rd_val); check("ds_cause", rd_val, 32'h8000_0010);
        @(negedge clk);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // mtc0 SR, then interrupt
        @(negedge clk);
        en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        tick();
        en = 1'b0;
        rd(5'd12, rd_val); check("mtc0_sr", rd_val, 32'h0000_0401);

        @(negedge clk);
        hw_int = 6'b000001; vpc = 32'h4000;
        #1;
`ifdef CP0_INT_SYNC_EN
        check("int_req_edge0", {31'b0, Req}, 32'd0);
        tick();
        check("int_req_edge1", {31'b0, Req}, 32'd0);
        tick();
        check("int_req_edge2", {31'b0, Req}, 32'd1);
`else
        check("int_req_same", {31'b0, Req}, 32'd1);
`endif
        tick();
        rd(5'd13, rd_val); check("int_cause", rd_val, 32'h0000_0400);
        rd(5'd12, rd_val); check("int_sr", rd_val, 32'h0000_0403);
        rd(5'd14, rd_val); check("int_epc", rd_val, 32'h0000_4000);
        check("int_masked_req", {31'b0, Req}, 32'd0);

        hw_int = 6'b0;
        repeat (3) tick();
        @(negedge clk);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd(5'd12, rd_val); check("int_eret_sr", rd_val, 32'h0000_0401);

        // Simultaneous interrupt and syscall, with a same-cycle mtc0 EPC
        @(negedge clk);
        hw_int = 6'b000001;
`ifdef CP0_INT_SYNC_EN
        tick();
        tick();
`endif
        exc_code_in = 5'd8; vpc = 32'h5000;
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_DEAD;
        #1;
        check("simul_req", {31'b0, Req}, 32'd1);
        tick();
        exc_code_in = 5'd0; en = 1'b0;
        rd(5'd13, rd_val); check("simul_cause", rd_val, 32'h0000_0400);
        rd(5'd14, rd_val); check("simul_epc", rd_val, 32'h0000_5000);

        // Reset mid-handler with the interrupt line still high
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_req", {31'b0, Req}, 32'd0);
        check("midrst_epc_out", epc_out, 32'd0);
        rd(5'd12, rd_val); check("midrst_sr", rd_val, 32'd0);
        rd(5'd13, rd_val); check("midrst_cause", rd_val, 32'd0);
        rd(5'd14, rd_val); check("midrst_epc", rd_val, 32'd0);
        hw_int = 6'b0;
        @(negedge clk);
        reset = 1'b0;

        // Writes to Cause and PRId are dropped
        @(negedge clk);
        en = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
        tick();
        cp0_addr = 5'd15; cp0_wdata = 32'h0;
        tick();
        en = 1'b0;
        rd(5'd13, rd_val); check("wr_cause_drop", rd_val, 32'd0);
        rd(5'd15, rd_val); check("wr_prid_drop", rd_val, 32'h0000_2024);

        // EPC bypass to epc_out, no write-through on read
        @(negedge clk);
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
        #1;
        check("epc_bypass", epc_out, 32'h0000_1234);
        check("epc_read_pre", cp0_rdata, 32'd0);
        tick();
        en = 1'b0;
        rd(5'd14, rd_val); check("epc_written", rd_val, 32'h0000_1234);
        rd(5'd20, rd_val); check("rd_unmapped", rd_val, 32'd0);

        // Delay-slot EPC wraps at address 0
        @(negedge clk);
        exc_code_in = 5'd4; bd_in = 1'b1; vpc = 32'h0;
        #1;
        check("wrap_req", {31'b0, Req}, 32'd1);
        tick();
        exc_code_in = 5'd0; bd_in = 1'b0;
        rd(5'd14, rd_val); check("wrap_epc", rd_val, 32'hFFFF_FFFC);
        rd(5'd13, rd_val); check("wrap_cause", rd_val, 32'h8000_0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
